// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Purpose  : Shared constants for the load/store front-end: access-size codes,
//             FSM state encoding, the byte-to-word index shift and a helper
//             that flags illegal size/alignment combinations.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access-size codes carried on req_size
    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_rd   = 2'b01;
    localparam logic [1:0] c_st_wr   = 2'b10;
    localparam logic [1:0] c_st_resp = 2'b11;

    // Byte address >> c_word_shift gives the 32-bit word index
    localparam int c_word_shift = 2;

    // True for an undefined size code or a half/word access that is not
    // naturally aligned. Byte accesses are always aligned.
    function automatic logic f_bad_shape(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
        logic w_bad;
        w_bad = 1'b0;
        case (size)
            c_sz_byte: w_bad = 1'b0;
            c_sz_half: w_bad = addr_lo[0];
            c_sz_word: w_bad = (addr_lo != 2'b00);
            default:   w_bad = 1'b1;
        endcase
        return w_bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Bundles the datapath request/response handshake and the data
//             memory bus of mem_access_unit.
//  Ports    : req_*   - request from the datapath
//             resp_*  - completion back to the datapath
//             busy    - pipeline stall
//             mem_*   - word-wide bus to the data memory
//  Modports : slave   - the access unit itself
//             master  - the environment (datapath plus memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              busy;

    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lane_align
//  Purpose  : Purely combinational little-endian lane logic.
//             - o_load_data : selected byte/half of i_rdata, sign- or
//               zero-extended; whole word for word accesses.
//             - o_merge_data: i_rdata with the selected lane replaced by the
//               low bits of i_wdata; i_wdata itself for word accesses.
//  Ports    : i_addr_lo[1:0], i_size[1:0], i_is_signed, i_rdata[31:0],
//             i_wdata[31:0] -> o_load_data[31:0], o_merge_data[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
module lane_align
    import mem_access_pkg::*;
(
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_is_signed,
    input  wire logic [31:0] i_rdata,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_load_data,
    output logic      [31:0] o_merge_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_byte_pos;
    logic [4:0]  w_half_pos;

    // Bit offsets of the addressed byte and half lanes
    assign w_byte_pos = {i_addr_lo, 3'b000};
    assign w_half_pos = {i_addr_lo[1], 4'b0000};

    assign w_byte = i_rdata[w_byte_pos +: 8];
    assign w_half = i_rdata[w_half_pos +: 16];

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            c_sz_byte: o_load_data = {{24{i_is_signed & w_byte[7]}}, w_byte};
            c_sz_half: o_load_data = {{16{i_is_signed & w_half[15]}}, w_half};
            default:   o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        o_merge_data = i_rdata;
        case (i_size)
            c_sz_byte: o_merge_data[w_byte_pos +: 8]  = i_wdata[7:0];
            c_sz_half: o_merge_data[w_half_pos +: 16] = i_wdata[15:0];
            default:   o_merge_data = i_wdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store front-end for a word-wide data memory. Accepts one
//             request at a time, sequences single-cycle read/write strobes,
//             performs read-modify-write for byte/half stores and returns
//             extended load data. Misaligned, illegal-size and out-of-range
//             requests are answered with resp_err without touching memory.
//  Ports    : clk, rst_n (async, active-low)
//             bus (mem_access_unit_if.slave): request, response, busy and
//             memory bus signals
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 128
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_access_unit_if.slave  bus
);
    logic [1:0]        r_state;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_write;
    logic [31:0]       r_wdata;

    logic              r_req_ready;
    logic              r_busy;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [ADDR_W-1:0] w_word_idx;
    logic              w_req_err;
    logic [31:0]       w_word_addr;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

    assign w_word_idx  = bus.req_addr >> c_word_shift;
    assign w_req_err   = f_bad_shape(bus.req_size, bus.req_addr[1:0]) ||
                         (w_word_idx >= ADDR_W'(MEM_WORDS));
    assign w_word_addr = 32'({bus.req_addr[ADDR_W-1:2], 2'b00});

    // The lane logic sees mem_rdata directly; its outputs are only consumed
    // on the edge that ends RD, where they are registered into resp_rdata or
    // mem_wdata. Those registers therefore serve as the read buffer.
    lane_align u_lane_align (
        .i_addr_lo    (r_addr_lo),
        .i_size       (r_size),
        .i_is_signed  (r_signed),
        .i_rdata      (bus.mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_addr_lo    <= 2'b00;
            r_size       <= c_sz_byte;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle pulses
            r_resp_valid <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (bus.req_valid) begin
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_write     <= bus.req_write;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_req_err) begin
                            r_state      <= c_st_resp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else if (bus.req_write && (bus.req_size == c_sz_word)) begin
                            // Full-word store needs no read
                            r_state     <= c_st_wr;
                            r_mem_addr  <= w_word_addr;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= bus.req_wdata;
                        end else begin
                            r_state    <= c_st_rd;
                            r_mem_addr <= w_word_addr;
                            r_mem_read <= 1'b1;
                        end
                    end
                end

                c_st_rd: begin
                    if (r_write) begin
                        r_state     <= c_st_wr;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merge_data;
                    end else begin
                        r_state      <= c_st_resp;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_data;
                    end
                end

                c_st_wr: begin
                    r_state      <= c_st_resp;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                end

                default: begin
                    // RESP: response pulse is on the bus this cycle
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_resp_err  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the data memory.
- Accepts one datapath request at a time and sequences the memory's word-wide Mem_Read/Mem_Write strobes.
- Implements byte and halfword stores as a read-modify-write over two memory cycles.
- Returns aligned, sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_WORDS, 128, depth of the attached data memory in 32-bit words; any word index >= MEM_WORDS is an error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  access size, using the package size codes.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse; the request is complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, illegal size, or out of range.
- busy  output  1  high in every state except IDLE; drives the pipeline stall.
- mem_addr  output  32  word-aligned address to data memory (req_addr with bits [1:0] = 0).
- mem_wdata  output  32  merged write word.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_rdata  input  32  memory read data, sampled on the clock edge that ends the RD state.

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. req_ready=1. resp_valid=0, resp_err=0, busy=0, mem_read=0, mem_write=0. resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation: all strobes drop immediately, no write completes, and any pending response is lost.
- Accept: a request is taken on a clock edge where req_valid=1 in IDLE. Address, size, signed, write flag and wdata are registered at that edge. Requests arriving while busy are ignored, because req_ready=0.
- Check at accept: an error is raised for any of the following:
  - req_size = 2'b11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - (addr>>2) >= MEM_WORDS.
  On error the FSM goes IDLE->RESP with resp_err=1, and no memory strobe is asserted.
- States and transitions:
  - IDLE: on accept, go to RD for a load or a sub-word store; go to WR for a word store.
  - RD: mem_read=1 for exactly one cycle. mem_rdata is captured into rbuf at the end of the cycle. A load then goes to RESP; a sub-word store goes to WR.
  - WR: mem_write=1 for exactly one cycle. mem_wdata is either req_wdata (word store) or the merge (sub-word store). Merge: rbuf with the selected byte/half lane replaced by the low bits of req_wdata. Next state is RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE.
- Strobe rules: mem_read and mem_write are never asserted together. mem_addr is held stable from RD through WR.
- Lanes are little-endian: byte at addr[1:0]=0 occupies bits [7:0]; the half at addr[1]=1 occupies bits [31:16].
- Load extension: take the selected lane, then sign- or zero-extend it to 32 bits according to req_signed. Word loads ignore req_signed.
- Latency from the accept edge to resp_valid:
  - word load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: the next request can be accepted in the cycle after RESP.

Decomposition:
- Shared package mem_access_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding IDLE/RD/WR/RESP;
  - the word-index shift constant 2.
- One combinational sub-module, lane_align: performs load extraction with extension and store merge, given addr[1:0], size and signed. It is reused by verification as the reference model.

Test Plan:
- Preload word 3 = 0x8899AABB. Load byte, signed, addr 0x0D -> resp_rdata 0xFFFFFFAA at accept+2, resp_err=0, one mem_read pulse.
- Same word, load half, unsigned, addr 0x0E -> 0x00008899. Then load word at addr 0x0C -> 0x8899AABB.
- Store byte 0x55 to addr 0x0E over 0x8899AABB -> mem_read cycle, then mem_write with mem_wdata 0x8855AABB at accept+2, resp_valid at accept+3.
- Store word 0x12345678 to addr 0x10 -> no mem_read, mem_write at accept+1, resp_valid at accept+2. Memory word 4 = 0x12345678.
- Errors, all giving resp_err=1 at accept+1 with no strobes:
  - load half at 0x01;
  - load word at 0x02;
  - req_size=2'b11;
  - word access at 0x200 (index 128).
- Assert rst_n low during WR of a byte store -> mem_write drops immediately, memory is unchanged, and after release req_ready=1 and resp_valid=0. A req_valid held during a busy period is accepted only after RESP.
